// File: rtl/match_record_packer.sv
// Match record packer: buffers one frame of matched keypoint pairs and, on
// frame end, streams a header word (record count) followed by the packed
// 72-bit records over a valid/ready interface.
module match_record_packer #(
    parameter int DEPTH = 256,
    parameter int CW    = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [CW-1:0] i_src_coor_x,
    input  logic [CW-1:0] i_src_coor_y,
    input  logic [CW-1:0] i_src_depth,
    input  logic [CW-1:0] i_dst_coor_x,
    input  logic [CW-1:0] i_dst_coor_y,
    input  logic [CW-1:0] i_dst_depth,
    input  logic          i_frame_end,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [71:0]   o_data,
    output logic          o_last,
    output logic          o_overflow
);

    localparam int AW   = $clog2(DEPTH);
    localparam int NW   = AW + 1;       // count must reach DEPTH itself
    localparam int RECW = 6 * CW;       // six fields stored back to back
    localparam int PADW = 12 - CW;      // each field sits in a 12-bit slot

    typedef enum logic [1:0] {
        COLLECT,
        HEADER,
        DRAIN
    } state_t;

    state_t          state_q, state_d;
    logic [NW-1:0]   count_q, count_d;
    logic [AW-1:0]   rd_q, rd_d;
    logic            valid_q, valid_d;
    logic            last_q, last_d;
    logic [71:0]     data_q, data_d;
    logic            ovf_q, ovf_d;

    logic [RECW-1:0] mem_q [DEPTH];

    logic            full;
    logic            wr_en;
    logic [RECW-1:0] wr_rec;
    logic [NW-1:0]   n_hdr;
    logic [AW-1:0]   rd_nxt;

    // Spread the six stored fields into their 12-bit slots, upper pad bits zero.
    function automatic logic [71:0] expand_rec(input logic [RECW-1:0] r);
        expand_rec = {{PADW{1'b0}}, r[6*CW-1:5*CW],
                      {PADW{1'b0}}, r[5*CW-1:4*CW],
                      {PADW{1'b0}}, r[4*CW-1:3*CW],
                      {PADW{1'b0}}, r[3*CW-1:2*CW],
                      {PADW{1'b0}}, r[2*CW-1:CW],
                      {PADW{1'b0}}, r[CW-1:0]};
    endfunction

    // Header word is the record count zero-extended to the full word width.
    function automatic logic [71:0] header_word(input logic [NW-1:0] n);
        header_word = {{(72 - NW){1'b0}}, n};
    endfunction

    assign full    = (count_q == NW'(DEPTH));
    assign wr_en   = (state_q == COLLECT) && i_valid && !full;
    assign wr_rec  = {i_src_coor_x, i_src_coor_y, i_src_depth,
                      i_dst_coor_x, i_dst_coor_y, i_dst_depth};
    // A match coincident with frame end is counted in the header.
    assign n_hdr   = count_q + NW'(wr_en);
    assign rd_nxt  = rd_q + 1'b1;

    assign o_ready    = (state_q == COLLECT);
    assign o_valid    = valid_q;
    assign o_data     = data_q;
    assign o_last     = last_q;
    assign o_overflow = ovf_q;

    // Record storage: written at the current count while collecting; no reset needed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[count_q[AW-1:0]] <= wr_rec;
        end
    end

    // Control and registered output state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLLECT;
            count_q <= '0;
            rd_q    <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rd_q    <= rd_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state logic; the next output word is prepared so o_data is registered.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rd_d    = rd_q;
        valid_d = valid_q;
        last_d  = last_q;
        data_d  = data_q;
        ovf_d   = ovf_q;

        case (state_q)
            COLLECT: begin
                if (wr_en) begin
                    count_d = count_q + 1'b1;
                end
                if (i_valid && full) begin
                    ovf_d = 1'b1;
                end
                if (i_frame_end) begin
                    state_d = HEADER;
                    count_d = n_hdr;
                    valid_d = 1'b1;
                    data_d  = header_word(n_hdr);
                    last_d  = (n_hdr == '0);
                end
            end
            HEADER: begin
                if (i_ready) begin
                    if (count_q != '0) begin
                        state_d = DRAIN;
                        rd_d    = '0;
                        data_d  = expand_rec(mem_q[0]);
                        last_d  = (count_q == NW'(1));
                    end else begin
                        state_d = COLLECT;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        data_d  = '0;
                        ovf_d   = 1'b0;
                    end
                end
            end
            DRAIN: begin
                if (i_ready) begin
                    if (last_q) begin
                        state_d = COLLECT;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        data_d  = '0;
                        count_d = '0;
                        ovf_d   = 1'b0;
                    end else begin
                        rd_d   = rd_nxt;
                        data_d = expand_rec(mem_q[rd_nxt]);
                        last_d = ({1'b0, rd_nxt} == (count_q - NW'(1)));
                    end
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

endmodule

// File: tb/tb_match_record_packer.sv
// Testbench for match_record_packer: randomized frames against a queue-based
// reference model, with a scoreboard monitor checking every output word.
module tb_match_record_packer;

    localparam int DEPTH = 256;
    localparam int CW    = 10;

    logic          clk;
    logic          rst_n;
    logic          i_valid;
    logic          o_ready;
    logic [CW-1:0] i_src_coor_x, i_src_coor_y, i_src_depth;
    logic [CW-1:0] i_dst_coor_x, i_dst_coor_y, i_dst_depth;
    logic          i_frame_end;
    logic          o_valid;
    logic          i_ready;
    logic [71:0]   o_data;
    logic          o_last;
    logic          o_overflow;

    match_record_packer #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_src_coor_x (i_src_coor_x),
        .i_src_coor_y (i_src_coor_y),
        .i_src_depth  (i_src_depth),
        .i_dst_coor_x (i_dst_coor_x),
        .i_dst_coor_y (i_dst_coor_y),
        .i_dst_depth  (i_dst_depth),
        .i_frame_end  (i_frame_end),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_data       (o_data),
        .o_last       (o_last),
        .o_overflow   (o_overflow)
    );

    typedef struct packed {
        logic        ovf;
        logic        last;
        logic [71:0] data;
    } exp_t;

    exp_t        sb[$];      // expected output words, in order
    logic [71:0] acc[$];     // matches accepted in the current frame
    int          checks = 0;
    int          errors = 0;
    bit          ready_rand = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference record layout: each field at its fixed bit position.
    function automatic logic [71:0] ref_rec(input logic [9:0] sx, input logic [9:0] sy,
                                            input logic [9:0] sd, input logic [9:0] dx,
                                            input logic [9:0] dy, input logic [9:0] dd);
        logic [71:0] r;
        r = '0;
        r[69:60] = sx;
        r[57:48] = sy;
        r[45:36] = sd;
        r[33:24] = dx;
        r[21:12] = dy;
        r[9:0]   = dd;
        return r;
    endfunction

    task automatic drive_fields(input logic [9:0] sx, input logic [9:0] sy, input logic [9:0] sd,
                                input logic [9:0] dx, input logic [9:0] dy, input logic [9:0] dd);
        i_src_coor_x = sx; i_src_coor_y = sy; i_src_depth = sd;
        i_dst_coor_x = dx; i_dst_coor_y = dy; i_dst_depth = dd;
    endtask

    task automatic send_match(input logic [9:0] sx, input logic [9:0] sy, input logic [9:0] sd,
                              input logic [9:0] dx, input logic [9:0] dy, input logic [9:0] dd);
        drive_fields(sx, sy, sd, dx, dy, dd);
        i_valid = 1'b1;
        acc.push_back(ref_rec(sx, sy, sd, dx, dy, dd));
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic send_rand();
        send_match(10'($urandom), 10'($urandom), 10'($urandom),
                   10'($urandom), 10'($urandom), 10'($urandom));
    endtask

    // Frame end, optionally with a coincident match; builds the expected stream.
    task automatic end_frame(input bit with_match);
        int   n;
        bit   ovf;
        exp_t e;
        logic [9:0] f[6];
        if (with_match) begin
            for (int k = 0; k < 6; k++) f[k] = 10'($urandom);
            drive_fields(f[0], f[1], f[2], f[3], f[4], f[5]);
            i_valid = 1'b1;
            acc.push_back(ref_rec(f[0], f[1], f[2], f[3], f[4], f[5]));
        end
        i_frame_end = 1'b1;
        ovf = (acc.size() > DEPTH);
        n   = ovf ? DEPTH : acc.size();
        e.ovf = ovf; e.last = (n == 0); e.data = 72'(n);
        sb.push_back(e);
        for (int i = 0; i < n; i++) begin
            e.ovf = ovf; e.last = (i == n - 1); e.data = acc[i];
            sb.push_back(e);
        end
        acc.delete();
        @(posedge clk);
        #1;
        i_valid     = 1'b0;
        i_frame_end = 1'b0;
        chk("hdr_latency_valid", 72'(o_valid), 72'(1));
        chk("ready_low_in_header", 72'(o_ready), 72'(0));
    endtask

    // Wait for the expected stream to drain; optionally push junk inputs meanwhile.
    task automatic wait_drain(input bit junk);
        int cyc = 0;
        forever begin
            @(negedge clk);
            if (sb.size() == 0 && !o_valid) begin
                i_valid     = 1'b0;
                i_frame_end = 1'b0;
                break;
            end
            cyc++;
            if (cyc > 3000) begin
                checks++;
                errors++;
                $display("FAIL drain_timeout: got %0d words pending expected 0", sb.size());
                sb.delete();
                i_valid     = 1'b0;
                i_frame_end = 1'b0;
                break;
            end
            if (junk) begin
                @(posedge clk);
                #1;
                drive_fields(10'($urandom), 10'($urandom), 10'($urandom),
                             10'($urandom), 10'($urandom), 10'($urandom));
                i_valid     = 1'($urandom_range(0, 1));
                i_frame_end = 1'($urandom_range(0, 1));
            end
        end
    endtask

    // Downstream ready: steady or random, changed just after the rising edge.
    always @(posedge clk) begin
        #1;
        i_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: pops the scoreboard on each handshake and checks stall stability.
    logic [71:0] held_d;
    logic        held_l;
    bit          holding = 0;
    exp_t        mon_e;
    always @(negedge clk) begin
        if (!rst_n || !o_valid) begin
            holding = 0;
        end else begin
            if (holding) begin
                chk("stall_data_stable", o_data, held_d);
                chk("stall_last_stable", 72'(o_last), 72'(held_l));
            end
            if (i_ready) begin
                holding = 0;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got 0x%0h expected none", o_data);
                end else begin
                    mon_e = sb.pop_front();
                    chk("word_data", o_data, mon_e.data);
                    chk("word_last", 72'(o_last), 72'(mon_e.last));
                    chk("word_overflow", 72'(o_overflow), 72'(mon_e.ovf));
                end
            end else begin
                holding = 1;
                held_d  = o_data;
                held_l  = o_last;
            end
        end
    end

    initial begin
        int n;
        rst_n       = 1'b0;
        i_valid     = 1'b0;
        i_frame_end = 1'b0;
        i_ready     = 1'b1;
        drive_fields(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_o_valid", 72'(o_valid), 72'(0));
        chk("reset_o_last", 72'(o_last), 72'(0));
        chk("reset_o_data", o_data, 72'(0));
        chk("reset_o_overflow", 72'(o_overflow), 72'(0));
        chk("reset_o_ready", 72'(o_ready), 72'(1));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Three known matches, including maximum field values.
        send_match(1, 2, 3, 4, 5, 6);
        send_match(7, 8, 9, 10, 11, 12);
        send_match(639, 479, 1023, 0, 0, 0);
        chk("known_record_layout", acc[0], 72'h001002003004005006);
        end_frame(0);
        wait_drain(0);

        // Empty frame: single header word with last set.
        end_frame(0);
        wait_drain(0);
        chk("ready_after_empty_frame", 72'(o_ready), 72'(1));

        // Overflow: more matches than the buffer holds.
        for (int i = 0; i < DEPTH + 5; i++) send_rand();
        end_frame(0);
        chk("overflow_set_in_header", 72'(o_overflow), 72'(1));
        wait_drain(0);
        chk("overflow_cleared_after_frame", 72'(o_overflow), 72'(0));

        // Match coincident with frame end is the last record.
        send_rand();
        send_rand();
        end_frame(1);
        wait_drain(0);

        // Random frames with random downstream stalls and ignored inputs while draining.
        ready_rand = 1;
        for (int f = 0; f < 6; f++) begin
            n = $urandom_range(0, 24);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
                send_rand();
            end
            end_frame(1'($urandom_range(0, 1)));
            wait_drain(1);
        end
        ready_rand = 0;

        // Reset in the middle of a drain, then a fresh one-match frame.
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) send_rand();
        end_frame(0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        acc.delete();
        #1;
        chk("midreset_o_valid", 72'(o_valid), 72'(0));
        chk("midreset_o_last", 72'(o_last), 72'(0));
        chk("midreset_o_overflow", 72'(o_overflow), 72'(0));
        chk("midreset_o_ready", 72'(o_ready), 72'(1));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_rand();
        end_frame(0);
        wait_drain(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
